csr_unit: RTL and testbench

//  Master side of csr_if: executes CSRRW/S/C[I] uops, one at a time, for the OoO core.

---
 rtl/csr_unit.sv | 104 ++++++++++
 tb/tb_csr_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/csr_unit.sv
// csr_unit: executes one CSRRW/S/C[I] uop at a time; the old value goes to writeback
// at once, and the CSR write waits until the ROB commits the uop's tag.
module csr_unit #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             issue_valid_i,
    output logic             issue_ready_o,
    input  logic [2:0]       issue_op_i,
    input  logic [11:0]      issue_addr_i,
    input  logic [XLEN-1:0]  issue_src_i,
    input  logic             issue_src_zero_i,
    input  logic             issue_rd_zero_i,
    input  logic [TAG_W-1:0] issue_tag_i,
    output logic             csr_rvalid_o,
    output logic [11:0]      csr_raddr_o,
    input  logic [XLEN-1:0]  csr_rdata_i,
    output logic             csr_wvalid_o,
    output logic [11:0]      csr_waddr_o,
    output logic [XLEN-1:0]  csr_wdata_o,
    output logic             wb_valid_o,
    input  logic             wb_ready_i,
    output logic [TAG_W-1:0] wb_tag_o,
    output logic [XLEN-1:0]  wb_data_o,
    output logic             wb_illegal_o,
    input  logic             commit_valid_i,
    input  logic [TAG_W-1:0] commit_tag_i,
    input  logic             flush_i
);
    localparam logic [2:0] IDLE = 3'd0, READ = 3'd1, WB = 3'd2, WAIT_CMT = 3'd3, WRITE = 3'd4;
    logic [2:0]       r_state, w_next;
    logic [2:0]       r_op;
    logic [11:0]      r_addr;
    logic [XLEN-1:0]  r_src, r_old, r_new;
    logic             r_src_zero, r_rd_zero, r_need_wr, r_illegal;
    logic [TAG_W-1:0] r_tag;
    logic             w_illegal, w_rd, w_need_wr, w_commit;
    logic             w_in_idle, w_in_read, w_in_wb, w_in_wr;
    logic [XLEN-1:0]  w_old, w_new;
    // op[1:0]: 01 write, 10 set, 11 clear, 00 illegal; op[2] only selects the imm form
    assign w_illegal = r_op[1:0] == 2'b00;
    assign w_in_idle = rstn && r_state == IDLE;
    assign w_in_read = rstn && r_state == READ;
    assign w_in_wb   = rstn && r_state == WB;
    assign w_in_wr   = rstn && r_state == WRITE;
    assign w_rd      = w_in_read && !w_illegal && !(r_op[1:0] == 2'b01 && r_rd_zero);
    assign w_old     = w_rd ? csr_rdata_i : '0;
    assign w_new     = r_op[1:0] == 2'b01 ? r_src :
                       r_op[1:0] == 2'b10 ? (w_old | r_src) : (w_old & ~r_src);
    assign w_need_wr = !w_illegal && !(r_op[1] && r_src_zero);
    assign w_commit  = commit_valid_i && commit_tag_i == r_tag;
    always_comb begin
        w_next = IDLE;
        w_next = r_state == IDLE     ? ((issue_valid_i && !flush_i) ? READ : IDLE) :
                 r_state == READ     ? (flush_i ? IDLE : WB) :
                 r_state == WB       ? (flush_i ? IDLE : !wb_ready_i ? WB :
                                        r_need_wr ? WAIT_CMT : IDLE) :
                 r_state == WAIT_CMT ? (w_commit ? WRITE : flush_i ? IDLE : WAIT_CMT) :
                 IDLE;
    end
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_op       <= '0;
            r_addr     <= '0;
            r_src      <= '0;
            r_src_zero <= 1'b0;
            r_rd_zero  <= 1'b0;
            r_tag      <= '0;
            r_old      <= '0;
            r_new      <= '0;
            r_need_wr  <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && issue_valid_i && !flush_i) begin
                r_op       <= issue_op_i;
                r_addr     <= issue_addr_i;
                r_src      <= issue_src_i;
                r_src_zero <= issue_src_zero_i;
                r_rd_zero  <= issue_rd_zero_i;
                r_tag      <= issue_tag_i;
            end
            if (r_state == READ) begin
                r_old     <= w_old;
                r_new     <= w_new;
                r_need_wr <= w_need_wr;
                r_illegal <= w_illegal;
            end
        end
    end
    assign issue_ready_o = w_in_idle;
    assign csr_rvalid_o  = w_rd;
    assign csr_raddr_o   = w_in_read ? r_addr : '0;
    assign wb_valid_o    = w_in_wb && !flush_i;
    assign wb_tag_o      = w_in_wb ? r_tag : '0;
    assign wb_data_o     = w_in_wb ? r_old : '0;
    assign wb_illegal_o  = w_in_wb && r_illegal;
    assign csr_wvalid_o  = w_in_wr;
    assign csr_waddr_o   = w_in_wr ? r_addr : '0;
    assign csr_wdata_o   = w_in_wr ? r_new : '0;
endmodule

// File: tb/tb_csr_unit.sv
// tb_csr_unit: directed CSR uops; expected writeback results and CSR writes are
// queued at issue and checked by an independent monitor.
module tb_csr_unit;
    logic        clk = 1'b0;
    logic        rstn;
    logic        issue_valid_i, issue_ready_o;
    logic [2:0]  issue_op_i;
    logic [11:0] issue_addr_i;
    logic [63:0] issue_src_i;
    logic        issue_src_zero_i, issue_rd_zero_i;
    logic [4:0]  issue_tag_i;
    logic        csr_rvalid_o;
    logic [11:0] csr_raddr_o;
    logic [63:0] csr_rdata_i;
    logic        csr_wvalid_o;
    logic [11:0] csr_waddr_o;
    logic [63:0] csr_wdata_o;
    logic        wb_valid_o, wb_ready_i;
    logic [4:0]  wb_tag_o;
    logic [63:0] wb_data_o;
    logic        wb_illegal_o;
    logic        commit_valid_i;
    logic [4:0]  commit_tag_i;
    logic        flush_i;
    int checks = 0, errors = 0, n_wr = 0, w0;
    logic [69:0] wbq[$];
    logic [75:0] wrq[$];

    csr_unit #(.XLEN(64), .TAG_W(5)) dut (
        .clk(clk), .rstn(rstn),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_op_i(issue_op_i), .issue_addr_i(issue_addr_i), .issue_src_i(issue_src_i),
        .issue_src_zero_i(issue_src_zero_i), .issue_rd_zero_i(issue_rd_zero_i),
        .issue_tag_i(issue_tag_i),
        .csr_rvalid_o(csr_rvalid_o), .csr_raddr_o(csr_raddr_o), .csr_rdata_i(csr_rdata_i),
        .csr_wvalid_o(csr_wvalid_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_tag_o(wb_tag_o),
        .wb_data_o(wb_data_o), .wb_illegal_o(wb_illegal_o),
        .commit_valid_i(commit_valid_i), .commit_tag_i(commit_tag_i), .flush_i(flush_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h expected %h", n, a, e);
        end
    endtask

    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            if (wb_valid_o && wb_ready_i) begin
                if (wbq.size() == 0) chk("wb_unexpected", 64'd1, 64'd0);
                else begin
                    logic [69:0] e;
                    e = wbq.pop_front();
                    chk("wb_tag", {59'd0, wb_tag_o}, {59'd0, e[69:65]});
                    chk("wb_illegal", {63'd0, wb_illegal_o}, {63'd0, e[64]});
                    chk("wb_data", wb_data_o, e[63:0]);
                end
            end
            if (csr_wvalid_o) begin
                n_wr++;
                if (wrq.size() == 0) chk("wr_unexpected", 64'd1, 64'd0);
                else begin
                    logic [75:0] e;
                    e = wrq.pop_front();
                    chk("wr_addr", {52'd0, csr_waddr_o}, {52'd0, e[75:64]});
                    chk("wr_data", csr_wdata_o, e[63:0]);
                end
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (issue_ready_o) break;
        end
        chk("idle_timeout", {63'd0, issue_ready_o}, 64'd1);
    endtask

    task automatic issue(input logic [2:0] op, input logic [11:0] addr, input logic [63:0] src,
                         input logic sz, input logic rz, input logic [4:0] tag, input logic exp_rd);
        wait_idle();
        issue_valid_i = 1'b1; issue_op_i = op; issue_addr_i = addr; issue_src_i = src;
        issue_src_zero_i = sz; issue_rd_zero_i = rz; issue_tag_i = tag;
        @(posedge clk);
        #1 issue_valid_i = 1'b0;
        @(negedge clk);
        chk("rvalid", {63'd0, csr_rvalid_o}, {63'd0, exp_rd});
        chk("raddr", {52'd0, csr_raddr_o}, {52'd0, addr});
        chk("wb_early", {63'd0, wb_valid_o}, 64'd0);
        @(negedge clk);
        chk("wb_latency", {63'd0, wb_valid_o}, 64'd1);
    endtask

    task automatic cmt(input logic cv, input logic [4:0] tag, input logic fl);
        @(posedge clk);
        #1 commit_valid_i = cv; commit_tag_i = tag; flush_i = fl;
        @(posedge clk);
        #1 commit_valid_i = 1'b0; commit_tag_i = '0; flush_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rstn = 1'b0; issue_valid_i = 1'b0; issue_op_i = '0; issue_addr_i = '0; issue_src_i = '0;
        issue_src_zero_i = 1'b0; issue_rd_zero_i = 1'b0; issue_tag_i = '0; csr_rdata_i = '0;
        wb_ready_i = 1'b1; commit_valid_i = 1'b0; commit_tag_i = '0; flush_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {63'd0, issue_ready_o}, 64'd0);
        chk("rst_wb_valid", {63'd0, wb_valid_o}, 64'd0);
        chk("rst_rvalid", {63'd0, csr_rvalid_o}, 64'd0);
        chk("rst_wvalid", {63'd0, csr_wvalid_o}, 64'd0);
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {63'd0, issue_ready_o}, 64'd1);
        // CSRRS mcycle with rs1=x0: read only
        w0 = n_wr; csr_rdata_i = 64'h40;
        wbq.push_back({5'd1, 1'b0, 64'h40});
        issue(3'b010, 12'hB00, 64'h0, 1'b1, 1'b0, 5'd1, 1'b1);
        wait_idle();
        cmt(1'b1, 5'd1, 1'b0);
        repeat (3) @(negedge clk);
        chk("rs_x0_no_write", n_wr - w0, 64'd0);
        // CSRRW minstret, rd=x0: no read, write after commit
        w0 = n_wr; csr_rdata_i = 64'h1234;
        wbq.push_back({5'd2, 1'b0, 64'h0});
        wrq.push_back({12'hB02, 64'h10});
        issue(3'b001, 12'hB02, 64'h10, 1'b0, 1'b1, 5'd2, 1'b0);
        repeat (2) @(negedge clk);
        chk("wait_cmt_not_ready", {63'd0, issue_ready_o}, 64'd0);
        chk("no_write_before_commit", n_wr - w0, 64'd0);
        cmt(1'b1, 5'd2, 1'b0);
        repeat (3) @(negedge clk);
        chk("rw_one_write", n_wr - w0, 64'd1);
        // CSRRC tag 3: non-matching commit ignored
        w0 = n_wr; csr_rdata_i = 64'hFF;
        wbq.push_back({5'd3, 1'b0, 64'hFF});
        wrq.push_back({12'h340, 64'hF0});
        issue(3'b011, 12'h340, 64'h0F, 1'b0, 1'b0, 5'd3, 1'b1);
        repeat (2) @(negedge clk);
        cmt(1'b1, 5'd2, 1'b0);
        repeat (3) @(negedge clk);
        chk("rc_wrong_tag", n_wr - w0, 64'd0);
        cmt(1'b1, 5'd3, 1'b0);
        repeat (3) @(negedge clk);
        chk("rc_one_write", n_wr - w0, 64'd1);
        // flush in WAIT_CMT drops the write
        w0 = n_wr; csr_rdata_i = 64'h8;
        wbq.push_back({5'd4, 1'b0, 64'h8});
        issue(3'b010, 12'h300, 64'h1, 1'b0, 1'b0, 5'd4, 1'b1);
        repeat (2) @(negedge clk);
        cmt(1'b0, 5'd0, 1'b1);
        @(negedge clk);
        chk("flush_idle", {63'd0, issue_ready_o}, 64'd1);
        cmt(1'b1, 5'd4, 1'b0);
        repeat (2) @(negedge clk);
        chk("flush_no_write", n_wr - w0, 64'd0);
        // flush and matching commit together: commit wins
        w0 = n_wr;
        wbq.push_back({5'd5, 1'b0, 64'h8});
        wrq.push_back({12'h300, 64'h9});
        issue(3'b010, 12'h300, 64'h1, 1'b0, 1'b0, 5'd5, 1'b1);
        repeat (2) @(negedge clk);
        cmt(1'b1, 5'd5, 1'b1);
        repeat (3) @(negedge clk);
        chk("flush_commit_write", n_wr - w0, 64'd1);
        // writeback backpressure
        w0 = n_wr; csr_rdata_i = 64'h55; wb_ready_i = 1'b0;
        wbq.push_back({5'd6, 1'b0, 64'h55});
        wrq.push_back({12'h341, 64'h77});
        issue(3'b001, 12'h341, 64'h77, 1'b0, 1'b0, 5'd6, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", {63'd0, wb_valid_o}, 64'd1);
            chk("stall_data", wb_data_o, 64'h55);
            chk("stall_tag", {59'd0, wb_tag_o}, 64'd6);
            chk("stall_ready", {63'd0, issue_ready_o}, 64'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 wb_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        cmt(1'b1, 5'd6, 1'b0);
        repeat (3) @(negedge clk);
        chk("stall_one_write", n_wr - w0, 64'd1);
        // illegal op
        w0 = n_wr; csr_rdata_i = 64'hAA;
        wbq.push_back({5'd7, 1'b1, 64'h0});
        issue(3'b100, 12'h305, 64'h5, 1'b0, 1'b0, 5'd7, 1'b0);
        wait_idle();
        cmt(1'b1, 5'd7, 1'b0);
        repeat (2) @(negedge clk);
        chk("illegal_no_write", n_wr - w0, 64'd0);
        // reset while waiting for commit
        w0 = n_wr; csr_rdata_i = 64'h1;
        wbq.push_back({5'd8, 1'b0, 64'h1});
        issue(3'b001, 12'h342, 64'h3, 1'b0, 1'b0, 5'd8, 1'b1);
        repeat (2) @(negedge clk);
        chk("pre_rst_wait", {63'd0, issue_ready_o}, 64'd0);
        rstn = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready", {63'd0, issue_ready_o}, 64'd0);
        chk("mid_rst_wb", {63'd0, wb_valid_o}, 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        cmt(1'b1, 5'd8, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_no_write", n_wr - w0, 64'd0);
        chk("rst_back_idle", {63'd0, issue_ready_o}, 64'd1);
        chk("wbq_empty", 64'(wbq.size()), 64'd0);
        chk("wrq_empty", 64'(wrq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
